// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side controllers.
//   arb_state_t : arbiter FSM state encoding (IDLE / BURST)
//   idx_width   : width of a requester index for n requesters (never 0)
//   cnt_width   : width of a beat counter able to hold max_burst without wrapping
package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// rr_priority_sel: combinational round-robin priority search.
//   req        : request vector, one bit per requester
//   last_grant : index of the requester served most recently
//   grant      : one-hot winner, zero when nothing requests
//   idx        : index of the winner, zero when nothing requests
//   any        : at least one requester is active
// Search starts at (last_grant + 1) mod NUM_REQ and wraps around, so the
// requester served last has the lowest priority.
module rr_priority_sel #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Outer loop walks priority order, inner loop maps the rotated position
  // back onto a constant bit index so every select stays static.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int p = 0; p < NUM_REQ; p++) begin
        if (!any && req[p] && (p == ((int'(last_grant) + i) % NUM_REQ))) begin
          any      = 1'b1;
          grant[p] = 1'b1;
          idx      = IDX_W'(p);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter in front of a FIFO write port.
//   wr_clk       : clock, rising edge
//   wr_rst       : asynchronous active-low reset
//   i_req_data   : requester k data at [k*INT_FIFO_WIDTH +: INT_FIFO_WIDTH]
//   i_req_valid  : per-requester beat valid
//   i_req_last   : per-requester end-of-burst marker (qualified by valid)
//   o_req_ready  : per-requester ready (only the granted bit can be set)
//   o_data       : beat to the FIFO write side
//   o_valid      : beat valid to the FIFO write side
//   i_fifo_ready : FIFO write side can accept a beat
//   o_grant      : one-hot current grant, zero when idle
//   o_src        : index of the granted requester, zero when idle
// IDLE arbitrates for one cycle; BURST passes the winner straight through
// until it sends last or reaches INT_MAX_BURST beats, then one idle bubble.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int INT_FIFO_WIDTH = 32,
  parameter int INT_NUM_REQ    = 4,
  parameter int INT_MAX_BURST  = 16
) (
  input  logic                                  wr_clk,
  input  logic                                  wr_rst,
  input  logic [INT_NUM_REQ*INT_FIFO_WIDTH-1:0] i_req_data,
  input  logic [INT_NUM_REQ-1:0]                i_req_valid,
  input  logic [INT_NUM_REQ-1:0]                i_req_last,
  output logic [INT_NUM_REQ-1:0]                o_req_ready,
  output logic [INT_FIFO_WIDTH-1:0]             o_data,
  output logic                                  o_valid,
  input  logic                                  i_fifo_ready,
  output logic [INT_NUM_REQ-1:0]                o_grant,
  output logic [idx_width(INT_NUM_REQ)-1:0]     o_src
);

  localparam int SRC_W = idx_width(INT_NUM_REQ);
  localparam int CNT_W = cnt_width(INT_MAX_BURST);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(INT_MAX_BURST);
  localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(INT_NUM_REQ - 1);

  arb_state_t             state;
  arb_state_t             state_nx;
  logic [INT_NUM_REQ-1:0] grant_q;
  logic [SRC_W-1:0]       src_q;
  logic [SRC_W-1:0]       last_grant;
  logic [CNT_W-1:0]       beat_cnt;

  logic [INT_NUM_REQ-1:0] sel_grant;
  logic [SRC_W-1:0]       sel_idx;
  logic                   sel_any;

  logic                   gnt_last;
  logic                   xfer;
  logic                   burst_done;

  rr_priority_sel #(
    .NUM_REQ (INT_NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_rr_sel (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .grant      (sel_grant),
    .idx        (sel_idx),
    .any        (sel_any)
  );

  // State register
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (sel_any)    state_nx = ST_BURST;
      ST_BURST: if (burst_done) state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // Output logic: zero-latency pass-through of the granted requester.
  // grant_q is one-hot, so the loop acts as an AND-OR mux.
  always_comb begin
    o_data      = '0;
    o_valid     = 1'b0;
    o_req_ready = '0;
    gnt_last    = 1'b0;
    if (state == ST_BURST) begin
      for (int k = 0; k < INT_NUM_REQ; k++) begin
        if (grant_q[k]) begin
          o_data   = i_req_data[k*INT_FIFO_WIDTH +: INT_FIFO_WIDTH];
          o_valid  = i_req_valid[k];
          gnt_last = i_req_last[k];
        end
      end
      o_req_ready = grant_q & {INT_NUM_REQ{i_fifo_ready}};
    end
  end

  assign xfer       = o_valid & i_fifo_ready;
  assign burst_done = xfer & (gnt_last | ((beat_cnt + CNT_W'(1)) == MAX_CNT));

  assign o_grant = grant_q;
  assign o_src   = src_q;

  // Grant / beat counter registers. last_grant resets to the highest index
  // so requester 0 wins the first arbitration after reset.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      grant_q    <= '0;
      src_q      <= '0;
      beat_cnt   <= '0;
      last_grant <= LAST_INIT;
    end else begin
      if (state == ST_IDLE) begin
        if (sel_any) begin
          grant_q  <= sel_grant;
          src_q    <= sel_idx;
          beat_cnt <= '0;
        end
      end else begin
        if (xfer) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        if (burst_done) begin
          last_grant <= src_q;
          grant_q    <= '0;
          src_q      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (4 requesters, 32-bit data, bursts of 16).
module tb_fifo_wr_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 16;

  logic           wr_clk = 1'b0;
  logic           wr_rst;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   i_req_valid;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic [W-1:0]   o_data;
  logic           o_valid;
  logic           i_fifo_ready;
  logic [N-1:0]   o_grant;
  logic [1:0]     o_src;

  // Requester-side beat queues {last, data} and FIFO-side expected data.
  logic [32:0] rq    [N][$];
  logic [31:0] exp_q [N][$];

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(
    .INT_FIFO_WIDTH (W),
    .INT_NUM_REQ    (N),
    .INT_MAX_BURST  (MB)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .i_req_data   (i_req_data),
    .i_req_valid  (i_req_valid),
    .i_req_last   (i_req_last),
    .o_req_ready  (o_req_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_fifo_ready (i_fifo_ready),
    .o_grant      (o_grant),
    .o_src        (o_src)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic load_beat(input int k, input logic [31:0] d, input logic l);
    rq[k].push_back({l, d});
    exp_q[k].push_back(d);
  endtask

  task automatic drive_inputs();
    logic [32:0] b;
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        b = rq[k][0];
        i_req_valid[k]      = 1'b1;
        i_req_last[k]       = b[32];
        i_req_data[k*W +: W] = b[31:0];
      end else begin
        i_req_valid[k]      = 1'b0;
        i_req_last[k]       = 1'b0;
        i_req_data[k*W +: W] = '0;
      end
    end
  endtask

  // One clock: sample at the falling edge, apply requester handshakes,
  // then present the next beats just after the rising edge.
  task automatic tick(output logic xf, output logic [1:0] src, output logic [31:0] dat,
                      output logic [3:0] gnt, output logic vld);
    @(negedge wr_clk);
    xf  = o_valid & i_fifo_ready;
    src = o_src;
    dat = o_data;
    gnt = o_grant;
    vld = o_valid;
    for (int k = 0; k < N; k++) begin
      if (o_req_ready[k] && i_req_valid[k]) void'(rq[k].pop_front());
    end
    @(posedge wr_clk);
    #1;
    drive_inputs();
  endtask

  task automatic test_reset(input string tag);
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b0;
    #1;
    n_vec++;
    if (o_grant !== 4'b0 || o_src !== 2'd0 || o_valid !== 1'b0 || o_req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL %s_async grant=%b src=%0d valid=%b ready=%b required all zero",
               tag, o_grant, o_src, o_valid, o_req_ready);
    end
    @(posedge wr_clk);
    #1;
    n_vec++;
    if (o_grant !== 4'b0 || o_src !== 2'd0 || o_valid !== 1'b0 || o_req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL %s_held grant=%b src=%0d valid=%b ready=%b required all zero",
               tag, o_grant, o_src, o_valid, o_req_ready);
    end
    wr_rst = 1'b1;
  endtask

  task automatic test_two_req();
    logic xf, vld;
    logic [1:0] src;
    logic [31:0] dat, e;
    logic [3:0] gnt;
    logic [3:0] exp_g [8];
    exp_g = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    for (int i = 0; i < 3; i++) load_beat(0, 32'h10 + i, i == 2);
    for (int i = 0; i < 2; i++) load_beat(2, 32'h20 + i, i == 1);
    drive_inputs();
    for (int c = 0; c < 8; c++) begin
      tick(xf, src, dat, gnt, vld);
      n_vec++;
      if (gnt !== exp_g[c]) begin
        n_err++;
        $display("FAIL two_req_grant cycle %0d got %b required %b", c, gnt, exp_g[c]);
      end
      if (xf) begin
        n_vec++;
        if (exp_q[src].size() == 0) begin
          n_err++;
          $display("FAIL two_req_extra src=%0d data=%h got, no beat required", src, dat);
        end else begin
          e = exp_q[src].pop_front();
          if (dat !== e) begin
            n_err++;
            $display("FAIL two_req_data got %h required %h", dat, e);
          end
        end
      end
    end
    n_vec++;
    if (exp_q[0].size() != 0 || exp_q[2].size() != 0) begin
      n_err++;
      $display("FAIL two_req_left got %0d/%0d beats pending required 0/0",
               exp_q[0].size(), exp_q[2].size());
    end
  endtask

  task automatic test_max_burst();
    logic xf, vld;
    logic [1:0] src;
    logic [31:0] dat, e;
    logic [3:0] gnt, prev_g;
    int bursts[$];
    int cur_len;
    cur_len = 0;
    prev_g  = '0;
    for (int i = 0; i < 40; i++) load_beat(1, 32'h1000 + i, 1'b0);
    drive_inputs();
    for (int c = 0; c < 50; c++) begin
      tick(xf, src, dat, gnt, vld);
      if (xf) begin
        cur_len++;
        n_vec++;
        if (exp_q[src].size() == 0) begin
          n_err++;
          $display("FAIL max_extra src=%0d data=%h got, no beat required", src, dat);
        end else begin
          e = exp_q[src].pop_front();
          if (dat !== e) begin
            n_err++;
            $display("FAIL max_data got %h required %h", dat, e);
          end
        end
      end
      if (gnt == 4'b0 && prev_g != 4'b0) begin
        bursts.push_back(cur_len);
        cur_len = 0;
      end
      prev_g = gnt;
    end
    n_vec++;
    if (bursts.size() != 2 || bursts[0] != MB || bursts[1] != MB) begin
      n_err++;
      $display("FAIL max_bursts got %0d closed bursts (first %0d) required two of %0d",
               bursts.size(), (bursts.size() > 0) ? bursts[0] : -1, MB);
    end
    n_vec++;
    if (cur_len != 8) begin
      n_err++;
      $display("FAIL max_tail got %0d beats required 8", cur_len);
    end
    // No last was sent: the grant must be held with valid low.
    n_vec++;
    if (gnt !== 4'b0010 || vld !== 1'b0) begin
      n_err++;
      $display("FAIL max_hold grant=%b valid=%b required 0010/0", gnt, vld);
    end
    n_vec++;
    if (exp_q[1].size() != 0) begin
      n_err++;
      $display("FAIL max_left got %0d beats pending required 0", exp_q[1].size());
    end
  endtask

  task automatic test_rotation();
    logic xf, vld;
    logic [1:0] src;
    logic [31:0] dat, e;
    logic [3:0] gnt, prev_g;
    int seq[$];
    int cyc;
    cyc    = 0;
    prev_g = '0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 6; i++) load_beat(k, 32'h3000 + k*16 + i, (i == 2) || (i == 5));
    drive_inputs();
    for (int c = 0; c < 60; c++) begin
      tick(xf, src, dat, gnt, vld);
      cyc++;
      n_vec++;
      if ((gnt != 4'b0 && gnt !== (4'b1 << src)) || (gnt == 4'b0 && src !== 2'd0)) begin
        n_err++;
        $display("FAIL rot_src grant=%b src=%0d not consistent", gnt, src);
      end
      if (gnt != 4'b0 && prev_g == 4'b0) seq.push_back(int'(src));
      prev_g = gnt;
      if (xf) begin
        n_vec++;
        if (exp_q[src].size() == 0) begin
          n_err++;
          $display("FAIL rot_extra src=%0d data=%h got, no beat required", src, dat);
        end else begin
          e = exp_q[src].pop_front();
          if (dat !== e) begin
            n_err++;
            $display("FAIL rot_data got %h required %h", dat, e);
          end
        end
      end
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
    end
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (j >= seq.size() || seq[j] != j % 4) begin
        n_err++;
        $display("FAIL rot_order grant %0d got %0d required %0d", j,
                 (j < seq.size()) ? seq[j] : -1, j % 4);
      end
    end
    // 8 grants x (3 beats + 1 bubble) including the first arbitration cycle.
    n_vec++;
    if (cyc != 32) begin
      n_err++;
      $display("FAIL rot_cycles got %0d required 32", cyc);
    end
  endtask

  task automatic test_stall();
    logic xf, vld;
    logic [1:0] src;
    logic [31:0] dat, e;
    logic [3:0] gnt;
    int n_x;
    n_x = 0;
    for (int i = 0; i < 5; i++) load_beat(0, 32'hA0 + i, i == 4);
    drive_inputs();
    i_fifo_ready = 1'($urandom_range(0, 1));
    for (int c = 0; c < 200; c++) begin
      tick(xf, src, dat, gnt, vld);
      if (gnt == 4'b0001 && exp_q[0].size() > 0) begin
        n_vec++;
        if (vld !== 1'b1 || dat !== exp_q[0][0]) begin
          n_err++;
          $display("FAIL stall_mirror valid=%b data=%h required 1/%h", vld, dat, exp_q[0][0]);
        end
      end
      if (xf) begin
        n_x++;
        n_vec++;
        if (exp_q[src].size() == 0) begin
          n_err++;
          $display("FAIL stall_extra src=%0d data=%h got, no beat required", src, dat);
        end else begin
          e = exp_q[src].pop_front();
          if (dat !== e) begin
            n_err++;
            $display("FAIL stall_data got %h required %h", dat, e);
          end
        end
      end
      i_fifo_ready = 1'($urandom_range(0, 1));
      if (exp_q[0].size() == 0 && gnt == 4'b0 && n_x > 0) break;
    end
    i_fifo_ready = 1'b1;
    n_vec++;
    if (n_x != 5) begin
      n_err++;
      $display("FAIL stall_count got %0d transfers required 5", n_x);
    end
    n_vec++;
    if (rq[0].size() != 0) begin
      n_err++;
      $display("FAIL stall_handshake got %0d beats unaccepted required 0", rq[0].size());
    end
  endtask

  task automatic test_reset_mid();
    logic xf, vld;
    logic [1:0] src;
    logic [31:0] dat, e;
    logic [3:0] gnt, prev_g;
    int seq[$];
    int n_x;
    n_x    = 0;
    prev_g = '0;
    for (int i = 0; i < 8; i++) load_beat(1, 32'hB0 + i, i == 7);
    drive_inputs();
    for (int c = 0; c < 20 && n_x < 3; c++) begin
      tick(xf, src, dat, gnt, vld);
      if (xf) begin
        n_x++;
        e = exp_q[src].pop_front();
        n_vec++;
        if (dat !== e) begin
          n_err++;
          $display("FAIL rmid_data got %h required %h", dat, e);
        end
      end
    end
    n_vec++;
    if (n_x != 3) begin
      n_err++;
      $display("FAIL rmid_pre got %0d transfers required 3", n_x);
    end
    wr_rst = 1'b0;
    #1;
    n_vec++;
    if (o_grant !== 4'b0 || o_valid !== 1'b0 || o_req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL rmid_async grant=%b valid=%b ready=%b required all zero",
               o_grant, o_valid, o_req_ready);
    end
    for (int i = 0; i < 2; i++) load_beat(0, 32'hC0 + i, i == 1);
    drive_inputs();
    @(negedge wr_clk);
    n_vec++;
    if (o_valid !== 1'b0 || o_req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL rmid_no_xfer valid=%b ready=%b required 0/0000", o_valid, o_req_ready);
    end
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(xf, src, dat, gnt, vld);
      if (gnt != 4'b0 && prev_g == 4'b0) seq.push_back(int'(src));
      prev_g = gnt;
      if (xf) begin
        n_vec++;
        if (exp_q[src].size() == 0) begin
          n_err++;
          $display("FAIL rmid_extra src=%0d data=%h got, no beat required", src, dat);
        end else begin
          e = exp_q[src].pop_front();
          if (dat !== e) begin
            n_err++;
            $display("FAIL rmid_data got %h required %h", dat, e);
          end
        end
      end
      if (exp_q[0].size() + exp_q[1].size() == 0 && gnt == 4'b0) break;
    end
    n_vec++;
    if (seq.size() != 2 || seq[0] != 0 || seq[1] != 1) begin
      n_err++;
      $display("FAIL rmid_order got %0d grants (first %0d) required 0 then 1",
               seq.size(), (seq.size() > 0) ? seq[0] : -1);
    end
    n_vec++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      n_err++;
      $display("FAIL rmid_left got %0d/%0d beats pending required 0/0",
               exp_q[0].size(), exp_q[1].size());
    end
  endtask

  initial begin
    wr_rst       = 1'b0;
    i_req_data   = '0;
    i_req_valid  = '0;
    i_req_last   = '0;
    i_fifo_ready = 1'b1;
    test_reset("init");
    test_two_req();
    test_max_burst();
    test_reset("post_max");
    test_rotation();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
